// File: rtl/alu_shift_pkg.sv
// Shared decode constants for the ALU shift stage and its restore block.
// The forward shift stage and shift_restore both decode the control word
// through these helpers, so the field layout lives in exactly one place.
package alu_shift_pkg;

    // Control word layout: [0] direction, [WIDTH-2:1] amount, [WIDTH-1] fill.
    localparam int DIR_BIT = 0;
    localparam int AMT_LSB = 1;

    // Direction encodings carried in ctrl[DIR_BIT].
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Most significant bit of the amount field for a given operand width.
    function automatic int AMT_MSB(input int width);
        return width - 2;
    endfunction

    // Position of the fill bit for a given operand width.
    function automatic int FILL_BIT(input int width);
        return width - 1;
    endfunction

    // Width of the step counter and overflow index for a given operand width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    // Width of the amount field, kept at least one bit wide so that
    // declarations stay legal for the narrowest operand.
    function automatic int amt_width(input int width);
        return (width > 2) ? (width - 2) : 1;
    endfunction

    // State encoding shared by the restore FSM.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } restore_state_t;

endpackage

// File: rtl/shift_restore_step.sv
// One-bit restore step: moves the work word back one position against the
// original shift direction and re-inserts one overflow bit at the end that
// the forward shift vacated.
module shift_restore_step
    import alu_shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] work,
    input  logic             insert_bit,
    input  logic             dir,
    output logic [WIDTH-1:0] next_work
);

    // Left shifts lost their top bits, so restoring pushes bits back in at the
    // MSB; right shifts lost their bottom bits, so bits come back at the LSB.
    always_comb begin
        next_work = work;
        if (dir == DIR_RIGHT) begin
            next_work = {work[WIDTH-2:0], insert_bit};
        end else begin
            next_work = {insert_bit, work[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/shift_restore.sv
// Iterative inverse of the ALU shift unit. A request carries the shifted
// result, the overflow word and the original control word; the block walks
// the result back one bit per cycle, re-inserting overflow bits, and hands
// the reconstructed operand out on a valid/ready handshake.
module shift_restore
    import alu_shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] result,
    input  logic [WIDTH-1:0] overflow,
    input  logic [WIDTH-1:0] ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] operand,
    output logic             err
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam int AMT_W = amt_width(WIDTH);

    restore_state_t   state;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] ov_reg;
    logic             dir_reg;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] idx;

    logic [AMT_W-1:0] amount;
    logic [CNT_W-1:0] amount_cnt;
    logic             amount_zero;
    logic             amount_too_big;
    logic             accept;
    logic             insert_bit;
    logic [WIDTH-1:0] next_work;
    logic             unused_fill;

    // The amount field only exists when the operand is wider than two bits;
    // a two-bit operand has nothing but direction and fill.
    generate
        if (WIDTH > 2) begin : g_amount
            assign amount = ctrl[AMT_MSB(WIDTH):AMT_LSB];
        end else begin : g_no_amount
            assign amount = '0;
        end
    endgenerate

    // Fill only shaped the vacated bits of the forward shift; those bits are
    // shifted out again here, so the restore never needs it.
    assign unused_fill = ctrl[FILL_BIT(WIDTH)];

    // Decode the request once so the FSM reads as plain conditions.
    always_comb begin
        amount_zero    = (amount == '0);
        amount_too_big = (int'(amount) > WIDTH);
        amount_cnt     = CNT_W'(amount);
        accept         = in_valid & in_ready;
    end

    // Overflow bit feeding the current step; the index never leaves the
    // overflow word while a restore is in progress.
    always_comb begin
        insert_bit = 1'b0;
        if (int'(idx) < WIDTH) begin
            insert_bit = ov_reg[idx];
        end
    end

    shift_restore_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .work      (work),
        .insert_bit(insert_bit),
        .dir       (dir_reg),
        .next_work (next_work)
    );

    // Request FSM: accept in IDLE, one restore step per cycle in SHIFT, then
    // hold the registered result in DONE until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            ov_reg    <= '0;
            dir_reg   <= DIR_LEFT;
            count     <= '0;
            idx       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            operand   <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        work     <= result;
                        ov_reg   <= overflow;
                        dir_reg  <= ctrl[DIR_BIT];
                        in_ready <= 1'b0;
                        if (amount_zero) begin
                            state     <= DONE;
                            count     <= '0;
                            idx       <= '0;
                            operand   <= result;
                            err       <= 1'b0;
                            out_valid <= 1'b1;
                        end else if (amount_too_big) begin
                            state     <= DONE;
                            count     <= '0;
                            idx       <= '0;
                            operand   <= '0;
                            err       <= 1'b1;
                            out_valid <= 1'b1;
                        end else begin
                            state <= SHIFT;
                            count <= amount_cnt;
                            if (ctrl[DIR_BIT] == DIR_RIGHT) begin
                                idx <= amount_cnt - CNT_W'(1);
                            end else begin
                                idx <= '0;
                            end
                        end
                    end
                end

                SHIFT: begin
                    work  <= next_work;
                    count <= count - CNT_W'(1);
                    if (dir_reg == DIR_RIGHT) begin
                        idx <= idx - CNT_W'(1);
                    end else begin
                        idx <= idx + CNT_W'(1);
                    end
                    if (count <= CNT_W'(1)) begin
                        state     <= DONE;
                        operand   <= next_work;
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_restore.sv
// Directed bench for shift_restore at WIDTH=8: hand-computed restore cases,
// boundary amounts, backpressure, reset abort, and a forward-shift model
// driving random operands through the restore.
module tb_shift_restore;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] overflow;
    logic [WIDTH-1:0] ctrl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] operand;
    logic             err;

    int errors = 0;
    int checks = 0;

    shift_restore #(
        .WIDTH(WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .result   (result),
        .overflow (overflow),
        .ctrl     (ctrl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .operand  (operand),
        .err      (err)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, observed=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request, then count cycles (accept edge = 1) until out_valid.
    task automatic send(input logic [7:0] res, input logic [7:0] ov, input logic [7:0] ctl, output int lat);
        check("in_ready before request", in_ready, 1);
        result   = res;
        overflow = ov;
        ctrl     = ctl;
        in_valid = 1'b1;
        tick();
        lat      = 1;
        in_valid = 1'b0;
        result   = 8'h5A;
        overflow = 8'hC3;
        ctrl     = 8'h7F;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    // Consume the pending operand and confirm the block is back in IDLE.
    task automatic complete();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid after handshake", out_valid, 0);
        check("in_ready after handshake", in_ready, 1);
    endtask

    initial begin
        int         lat;
        logic       seen;
        logic [7:0] op;
        logic [7:0] res;
        logic [7:0] ov;
        logic [7:0] ctl;
        logic [15:0] t16;
        int         amt;
        logic       dir;
        logic       arith;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        result    = '0;
        overflow  = '0;
        ctrl      = '0;

        // Reset values
        #12;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset operand", operand, 0);
        check("reset err", err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Left restore, amount 3
        send(8'hA8, 8'h05, 8'h06, lat);
        check("left3 latency", lat, 4);
        check("left3 operand", operand, 8'hB5);
        check("left3 err", err, 0);
        check("left3 in_ready", in_ready, 0);
        complete();

        // Arithmetic right restore, amount 2
        send(8'hED, 8'h01, 8'h05, lat);
        check("right2 latency", lat, 3);
        check("right2 operand", operand, 8'hB5);
        check("right2 err", err, 0);
        complete();

        // Zero amount passes the result straight through
        send(8'h3C, 8'hFF, 8'h00, lat);
        check("zero latency", lat, 1);
        check("zero operand", operand, 8'h3C);
        check("zero err", err, 0);
        complete();

        // Amount 9 is out of range
        send(8'h77, 8'h11, 8'h12, lat);
        check("range latency", lat, 1);
        check("range operand", operand, 0);
        check("range err", err, 1);
        complete();

        // Amount equal to WIDTH, left and right: operand comes entirely from overflow
        send(8'h00, 8'hB5, 8'h10, lat);
        check("left8 latency", lat, 9);
        check("left8 operand", operand, 8'hB5);
        check("left8 err", err, 0);
        complete();
        send(8'hFF, 8'hB5, 8'h11, lat);
        check("right8 latency", lat, 9);
        check("right8 operand", operand, 8'hB5);
        complete();

        // Backpressure: hold out_ready low, pulse in_valid, outputs must stay put
        send(8'hA8, 8'h05, 8'h06, lat);
        check("bp latency", lat, 4);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            result   = 8'(i * 37);
            ctrl     = 8'h00;
            tick();
            check("bp out_valid", out_valid, 1);
            check("bp operand", operand, 8'hB5);
            check("bp err", err, 0);
            check("bp in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        complete();
        send(8'hED, 8'h01, 8'h05, lat);
        check("bp next latency", lat, 3);
        check("bp next operand", operand, 8'hB5);
        complete();

        // out_ready held high early: DONE still lasts one cycle
        out_ready = 1'b1;
        send(8'h3C, 8'h00, 8'h00, lat);
        check("early ready latency", lat, 1);
        check("early ready out_valid", out_valid, 1);
        check("early ready operand", operand, 8'h3C);
        tick();
        check("early ready drop", out_valid, 0);
        check("early ready in_ready", in_ready, 1);
        out_ready = 1'b0;

        // Reset mid-SHIFT on an amount-7 request aborts with no output
        result   = 8'h80;
        overflow = 8'h5A;
        ctrl     = 8'h0E;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("pre-abort in_ready", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort in_ready", in_ready, 1);
        check("abort out_valid", out_valid, 0);
        check("abort operand", operand, 0);
        check("abort err", err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("abort no out_valid", seen, 0);
        send(8'h80, 8'h5A, 8'h0E, lat);
        check("post-abort latency", lat, 8);
        check("post-abort operand", operand, 8'hB5);
        check("post-abort err", err, 0);
        complete();

        // Random operands through a forward shift model, then restored
        for (int n = 0; n < 24; n++) begin
            op    = 8'($urandom_range(0, 255));
            amt   = $urandom_range(0, 8);
            dir   = 1'($urandom_range(0, 1));
            arith = 1'($urandom_range(0, 1));
            if (!dir) begin
                t16 = {8'h00, op} << amt;
                res = t16[7:0];
                ov  = t16[15:8];
            end else begin
                t16 = {op, 8'h00} >> amt;
                res = t16[15:8];
                ov  = t16[7:0] >> (8 - amt);
                if (arith && op[7]) res = res | ~(8'hFF >> amt);
            end
            ctl = {arith, 6'(amt), dir};
            send(res, ov, ctl, lat);
            check("rand latency", lat, amt + 1);
            check("rand operand", operand, op);
            check("rand err", err, 0);
            complete();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
